lpc_out_scheduler: RTL
======================

// Module: lpc_out_scheduler
// PURPOSE
// Buffers decoded LPC cycle records from the lpc decoder (one strobe per completed cycle) in a
// small FIFO and schedules them onto a single byte-wide valid/ready stream (UART/USB TX side).
// Guarantees back-to-back LPC cycles with no idle clocks are captured losslessly up to FIFO depth.
// Counts records dropped on overflow.
// PARAMETERS
// FIFO_DEPTH  8   record slots; power of two, >= 2
// FIFO_AW     3   log2(FIFO_DEPTH)
// PORTS
// lpc_clock       in   1   sole clock, all logic on rising edge
// lpc_reset       in   1   asynchronous, active-low reset
// in_strobe       in   1   one-clock pulse: record on in_* valid this clock
// in_cyctype_dir  in   4   cycle type / direction from decoder
// in_addr         in   32  cycle address
// in_data         in   32  cycle data, byte 0 in [7:0]
// in_data_size    in   4   number of data bytes
// out_byte        out  8   stream byte
// out_valid       out  1   out_byte valid
// out_ready       in   1   sink accepts out_byte when out_valid && out_ready
// fifo_level      out  FIFO_AW+1  records currently buffered
// overflow_count  out  16  records dropped, saturating
// busy            out  1   FSM not IDLE or FIFO non-empty
// BEHAVIOUR
// - Reset (lpc_reset low, async): out_byte=0, out_valid=0, fifo_level=0, overflow_count=0, busy=0,
//   FSM=IDLE, FIFO pointers cleared; any partially sent record discarded.
// - FIFO entry 72 bits {cyctype_dir, data_size, addr, data}. Write on in_strobe if not full.
//   Full is evaluated after a same-clock pop: strobe while full and popping is accepted.
// - Strobe while full and no pop: record dropped, overflow_count += 1, saturates at 16'hFFFF.
// - Record byte order: HDR={cyctype_dir,data_size} (raw), ADDR[31:24],[23:16],[15:8],[7:0],
//   then N data bytes low byte first, N = min(data_size,4); data_size 0 -> no data bytes.
// - FSM: IDLE -> (FIFO non-empty: pop into shift register) -> HDR -> ADDR(4 bytes, counter 3..0)
//   -> DATA (N bytes; skipped if N=0) -> IDLE. State advances only on a byte handshake.
// - out_valid registered; asserted the clock after pop. out_byte/out_valid held stable while
//   out_valid && !out_ready. No combinational path from out_ready to out_valid.
// - Latency: strobe at edge T with FSM idle and FIFO empty -> header valid after edge T+2.
// - Between records: exactly one clock with out_valid=0 (IDLE pop cycle).
// - Simultaneous strobe and pop: level unchanged; wrap-around of pointers mod FIFO_DEPTH.
// - fifo_level updates same edge as write/pop; busy = (state!=IDLE) | (fifo_level!=0).
// CONFIGURATION
// LPC_OUT_SYNC_EN defined: SYNC state before HDR emits byte 8'hA5 per record; record length +1,
//   header latency unchanged (SYNC byte valid at T+2, header after its handshake).
// LPC_OUT_SYNC_EN undefined: no SYNC state; record starts with HDR.
// TESTING
// 1 single I/O read ct=0 addr=16'h7fe5 data=8'h6c size=1, out_ready=1 -> 01 00 00 7f e5 6c
//   (A5 prefix with LPC_OUT_SYNC_EN); out_valid first high 2 clocks after strobe.
// 2 two strobes on consecutive clocks (7fe4/6b, 7fe5/6c), out_ready=0 -> fifo_level=2,
//   overflow_count=0; release ready -> 12 bytes in order, one idle clock between records.
// 3 out_ready=0, 10 strobes, FIFO_DEPTH=8 -> fifo_level=8, overflow_count=2; drain -> first 8 only.
// 4 out_ready toggled 1/0 every clock during a record -> out_byte stable while stalled, no dup/skip.
// 5 data_size 0 -> 5 bytes; size 4 data 32'h11223344 -> data 44 33 22 11; size 9 -> 4 data bytes,
//   header 0x?9 unchanged.
// 6 lpc_reset low mid-ADDR with 3 records queued -> all outputs 0 immediately; after release
//   out_valid stays 0 until new strobe, no partial bytes emitted.

Source files
------------

// File: rtl/lpc_out_scheduler.sv
// rtl/lpc_out_scheduler.sv - buffers decoded LPC cycle records and serialises them onto a byte stream
// Optional build macro LPC_OUT_SYNC_EN prefixes every record with a 8'hA5 sync byte.
module lpc_out_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               lpc_clock,
    input  logic               lpc_reset,
    input  logic               in_strobe,
    input  logic [3:0]         in_cyctype_dir,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_data,
    input  logic [3:0]         in_data_size,
    output logic [7:0]         out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        overflow_count,
    output logic               busy
);

`ifdef LPC_OUT_SYNC_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HDR, S_ADDR, S_DATA} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_DATA} state_t;
`endif

    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    // entry layout: [71:68] cyctype_dir, [67:64] data_size, [63:32] addr, [31:0] data
    logic [71:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [71:0]        rd_entry;
    logic               pop, push, full, hs;

    state_t      state, state_d;
    logic [7:0]  byte_d;
    logic        valid_d;
    logic [31:0] addr_sr, addr_d, data_sr, data_d;
    logic [1:0]  cnt, cnt_d;
    logic [2:0]  nleft, nleft_d;
`ifdef LPC_OUT_SYNC_EN
    logic [7:0]  hdr_r, hdr_d;
`endif

    assign rd_entry = mem[rd_ptr];
    assign hs       = out_valid && out_ready;
    // Records stay in the FIFO while the sink stalls, so fifo_level reflects the real backlog.
    assign pop      = (state == S_IDLE) && (fifo_level != '0) && out_ready;
    assign full     = (fifo_level == LEVEL_FULL) && !pop;
    assign push     = in_strobe && !full;
    assign busy     = (state != S_IDLE) || (fifo_level != '0);

    always_ff @(posedge lpc_clock) begin
        if (push)
            mem[wr_ptr] <= {in_cyctype_dir, in_data_size, in_addr, in_data};
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            overflow_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            if (in_strobe && full && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state     <= S_IDLE;
            out_byte  <= '0;
            out_valid <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            cnt       <= '0;
            nleft     <= '0;
`ifdef LPC_OUT_SYNC_EN
            hdr_r     <= '0;
`endif
        end else begin
            state     <= state_d;
            out_byte  <= byte_d;
            out_valid <= valid_d;
            addr_sr   <= addr_d;
            data_sr   <= data_d;
            cnt       <= cnt_d;
            nleft     <= nleft_d;
`ifdef LPC_OUT_SYNC_EN
            hdr_r     <= hdr_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        byte_d  = out_byte;
        valid_d = out_valid;
        addr_d  = addr_sr;
        data_d  = data_sr;
        cnt_d   = cnt;
        nleft_d = nleft;
`ifdef LPC_OUT_SYNC_EN
        hdr_d   = hdr_r;
`endif
        case (state)
            S_IDLE: begin
                if (pop) begin
                    addr_d  = rd_entry[63:32];
                    data_d  = rd_entry[31:0];
                    nleft_d = (rd_entry[67:64] > 4'd4) ? 3'd4 : rd_entry[66:64];
                    valid_d = 1'b1;
`ifdef LPC_OUT_SYNC_EN
                    hdr_d   = rd_entry[71:64];
                    byte_d  = 8'hA5;
                    state_d = S_SYNC;
`else
                    byte_d  = rd_entry[71:64];
                    state_d = S_HDR;
`endif
                end
            end
`ifdef LPC_OUT_SYNC_EN
            S_SYNC: begin
                if (hs) begin
                    byte_d  = hdr_r;
                    state_d = S_HDR;
                end
            end
`endif
            S_HDR: begin
                if (hs) begin
                    byte_d  = addr_sr[31:24];
                    addr_d  = {addr_sr[23:0], 8'h00};
                    cnt_d   = 2'd3;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (hs) begin
                    if (cnt != 2'd0) begin
                        byte_d = addr_sr[31:24];
                        addr_d = {addr_sr[23:0], 8'h00};
                        cnt_d  = cnt - 2'd1;
                    end else if (nleft != 3'd0) begin
                        byte_d  = data_sr[7:0];
                        data_d  = {8'h00, data_sr[31:8]};
                        state_d = S_DATA;
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                // nleft counts the byte currently presented as well as those still to come
                if (hs) begin
                    if (nleft == 3'd1) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        nleft_d = nleft - 3'd1;
                        byte_d  = data_sr[7:0];
                        data_d  = {8'h00, data_sr[31:8]};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
